alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU for the execute stage. It covers the base single-cycle ops
//  (add/sub/logic/shift) plus iterative multiply, divide and remainder. Operands and results

---
 rtl/alu_mc.sv | 208 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the execute stage.
// Single-cycle add/sub/logic/shift ops finish in one cycle. Multiply, unsigned
// divide and remainder iterate one bit per cycle. Operands come in over a
// valid/ready handshake and results leave over one. Result and Z/V/N flags are
// registered and travel together.
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter int OPC_W  = 5,
  parameter int MULDIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(5'h02);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(5'h05);
  localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(5'h06);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(5'h07);
  localparam logic [OPC_W-1:0] OP_SLL = OPC_W'(5'h08);
  localparam logic [OPC_W-1:0] OP_SRL = OPC_W'(5'h09);
  localparam logic [OPC_W-1:0] OP_SRA = OPC_W'(5'h0A);
  localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(5'h0B);
  localparam logic [OPC_W-1:0] OP_DIV = OPC_W'(5'h0C);
  localparam logic [OPC_W-1:0] OP_REM = OPC_W'(5'h0D);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {MC_MUL, MC_DIV, MC_REM} mc_op_t;

  // Registered single-cycle outcome, bundled so it can be written as one unit
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             v;
    logic             n;
  } rsp_t;

  state_t           state;
  mc_op_t           mc_op;
  logic [SH_W-1:0]  cnt;
  logic             fin;      // all WIDTH iterations done; next BUSY cycle publishes
  logic [WIDTH-1:0] acc_hi;   // mul: partial product high half; div: partial remainder
  logic [WIDTH-1:0] acc_lo;   // mul: multiplier / product low half; div: dividend / quotient
  logic [WIDTH-1:0] opnd;     // mul: multiplicand; div: divisor

  logic             accept;
  logic             is_mc;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] addsub;
  logic [SH_W-1:0]  shamt;
  rsp_t             sc;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_tr;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  rsp_t             mc;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign is_mc    = (MULDIV != 0) &&
                    ((opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_REM));

  // Shared adder: subtract is a + ~b + 1, so one overflow rule covers both
  assign is_sub = (opcode == OP_SUB);
  assign b_eff  = is_sub ? ~operand_b : operand_b;
  assign addsub = operand_a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
  assign shamt  = operand_b[SH_W-1:0];

  // Single-cycle datapath; anything not decoded (incl. mul/div when MULDIV=0) adds
  always_comb begin
    sc.res = addsub;
    sc.v   = (operand_a[MSB] == b_eff[MSB]) && (addsub[MSB] != operand_a[MSB]);
    sc.n   = addsub[MSB];
    case (opcode)
      OP_AND: begin sc.res = operand_a & operand_b; sc.v = 1'b0; sc.n = 1'b0; end
      OP_OR:  begin sc.res = operand_a | operand_b; sc.v = 1'b0; sc.n = 1'b0; end
      OP_XOR: begin sc.res = operand_a ^ operand_b; sc.v = 1'b0; sc.n = 1'b0; end
      OP_SLL: begin sc.res = operand_a << shamt;    sc.v = 1'b0; sc.n = 1'b0; end
      OP_SRL: begin sc.res = operand_a >> shamt;    sc.v = 1'b0; sc.n = 1'b0; end
      OP_SRA: begin sc.res = $signed(operand_a) >>> shamt; sc.v = 1'b0; sc.n = 1'b0; end
      default: ;
    endcase
    sc.z = (sc.res == '0);
  end

  // One iteration: LSB-first shift-add for mul, restoring subtract for div/rem.
  // A zero divisor never underflows, so quotient fills with ones and the
  // remainder ends up equal to the dividend without special casing.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_tr   = {acc_hi, acc_lo[MSB]};
    div_diff = div_tr - {1'b0, opnd};
    if (mc_op == MC_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[MSB:1]};
    end else if (div_diff[WIDTH]) begin
      step_hi = div_tr[WIDTH-1:0];
      step_lo = {acc_lo[MSB-1:0], 1'b0};
    end else begin
      step_hi = div_diff[WIDTH-1:0];
      step_lo = {acc_lo[MSB-1:0], 1'b1};
    end
  end

  // Final multi-cycle result and flags, picked from the accumulators
  always_comb begin
    mc.res = acc_lo;
    mc.v   = (opnd == '0);
    mc.n   = 1'b0;
    case (mc_op)
      MC_MUL: begin mc.v = (acc_hi != '0); mc.n = acc_lo[MSB]; end
      MC_REM: mc.res = acc_hi;
      default: ;
    endcase
    mc.z = (mc.res == '0);
  end

  // Control FSM plus result/flag and iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mc_op     <= MC_MUL;
      cnt       <= '0;
      fin       <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      z         <= 1'b0;
      v         <= 1'b0;
      n         <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
      fin       <= 1'b0;
    end else if (accept) begin
      if (is_mc) begin
        state     <= BUSY;
        out_valid <= 1'b0;
        cnt       <= SH_W'(WIDTH - 1);
        fin       <= 1'b0;
        acc_hi    <= '0;
        if (opcode == OP_MUL) begin
          mc_op  <= MC_MUL;
          acc_lo <= operand_b;
          opnd   <= operand_a;
        end else begin
          mc_op  <= (opcode == OP_DIV) ? MC_DIV : MC_REM;
          acc_lo <= operand_a;
          opnd   <= operand_b;
        end
      end else begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= sc.res;
        z         <= sc.z;
        v         <= sc.v;
        n         <= sc.n;
      end
    end else begin
      case (state)
        BUSY: begin
          if (fin) begin
            state     <= DONE;
            out_valid <= 1'b1;
            fin       <= 1'b0;
            result    <= mc.res;
            z         <= mc.z;
            v         <= mc.v;
            n         <= mc.n;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (cnt == '0) fin <= 1'b1;
            else           cnt <= cnt - SH_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vectors with hand-computed expectations pushed
// into a scoreboard at accept time; a negedge monitor pops on each handshake.
module tb_alu_mc;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         v;
    logic         n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   opcode = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         z, v, n;

  int   applied = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   pop_cyc[$];

  alu_mc #(.WIDTH(W), .OPC_W(5), .MULDIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .z(z), .v(v), .n(n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {29'd0, result, z, v, n}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_flags", {29'd0, result, z, v, n}, {29'd0, e});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Present one op; returns 1 ns after the accepting edge
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input exp_t e);
    bit ok;
    ok = 1'b0;
    opcode = op; operand_a = a; operand_b = b; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic vec(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] r, input logic ez, input logic ev, input logic en);
    exp_t e;
    e = '{res: r, z: ez, v: ev, n: en};
    issue(op, a, b, 1'b1, e);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    if (!ok) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t none;
    none = '0;

    // Reset state
    #2;
    chk("reset_outputs", {31'd0, out_valid, result, z, v, n}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    // T1: add overflow, latency 1
    vec(5'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 1);
    @(negedge clk);
    chk("add_latency1", {63'd0, out_valid}, 64'd1);
    drain();

    // Other single-cycle ops
    vec(5'h02, 32'd5,         32'd5, 32'd0,         1, 0, 0);
    vec(5'h02, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 0);
    vec(5'h0A, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 0);
    vec(5'h09, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 0, 0);
    vec(5'h08, 32'd1,     32'h21, 32'd2,    0, 0, 0);
    vec(5'h07, 32'hFF,    32'hFF, 32'd0,    1, 0, 0);
    vec(5'h06, 32'hF0,    32'h0F, 32'hFF,   0, 0, 0);
    vec(5'h1F, 32'd1,     32'd2,  32'd3,    0, 0, 0);
    drain();

    // T3: mul latency and in_ready low while busy
    begin
      int bad_v, bad_r;
      bad_v = 0; bad_r = 0;
      vec(5'h0B, 32'h0001_0000, 32'h0001_0000, 32'd0, 1, 1, 0);
      for (int k = 0; k <= 32; k++) begin
        @(negedge clk);
        if (out_valid) bad_v++;
        if (in_ready)  bad_r++;
      end
      chk("mul_early_valid", 64'(bad_v), 64'd0);
      chk("mul_in_ready_busy", 64'(bad_r), 64'd0);
      @(negedge clk);
      chk("mul_valid_at_33", {63'd0, out_valid}, 64'd1);
      drain();
    end
    vec(5'h0B, 32'd3,         32'd5, 32'd15,         0, 0, 0);
    vec(5'h0B, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE,  0, 1, 1);

    // T4: divide / remainder incl. divide by zero
    vec(5'h0C, 32'd100, 32'd7, 32'd14,         0, 0, 0);
    vec(5'h0D, 32'd100, 32'd7, 32'd2,          0, 0, 0);
    vec(5'h0C, 32'd5,   32'd0, 32'hFFFF_FFFF,  0, 1, 0);
    vec(5'h0D, 32'd5,   32'd0, 32'd5,          0, 1, 0);
    drain();

    // T5: backpressure hold, then back-to-back results
    out_ready = 1'b0;
    vec(5'h05, 32'hF0, 32'h3C, 32'h30, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_result", {31'd0, out_valid, in_ready, result[29:0]}, {31'd0, 1'b1, 1'b0, 30'h30});
    end
    @(posedge clk); #1;
    pop_cyc.delete();
    out_ready = 1'b1;
    vec(5'h00, 32'd1,  32'd1, 32'd2,  0, 0, 0);
    vec(5'h02, 32'd10, 32'd3, 32'd7,  0, 0, 0);
    vec(5'h07, 32'hA,  32'h5, 32'hF,  0, 0, 0);
    drain();
    chk("b2b_count", 64'(pop_cyc.size()), 64'd4);
    if (pop_cyc.size() == 4)
      for (int i = 0; i < 3; i++)
        chk("b2b_spacing", 64'(pop_cyc[i+1] - pop_cyc[i]), 64'd1);

    // T6: flush mid-mul
    issue(5'h0B, 32'd3, 32'd5, 1'b0, none);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("flush_no_valid", 64'(seen), 64'd0);
    end

    // Async reset mid-div
    @(posedge clk); #1;
    issue(5'h0C, 32'd100, 32'd7, 1'b0, none);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {31'd0, out_valid, result, z, v, n}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_post_reset", {63'd0, in_ready}, 64'd1);
    vec(5'h00, 32'd2, 32'd3, 32'd5, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
